// File: rtl/shift_unit_arbiter.sv
// Two-port valid/ready arbiter sharing one 64-bit shifter for RV32 SLL/SRL/SRA.
// Stage 1 registers the granted request; stage 2 registers the low 32 result bits with tag/source.
module shift_unit_arbiter #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned RR_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [3:0]         req_op_i,
  input  logic [63:0]        req_operand_i,
  input  logic [9:0]         req_shamt_i,
  input  logic [2*TAG_W-1:0] req_tag_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [31:0]        resp_data_o,
  output logic [TAG_W-1:0]   resp_tag_o,
  output logic               resp_src_o,
  output logic               resp_err_o
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Shared shifter; the reserved mode passes data through untouched.
  function automatic logic [63:0] shifter_64bit(
    input logic [63:0] data_in,
    input logic [63:0] shift_amount,
    input logic [1:0]  mode
  );
    logic        ovf;
    logic [5:0]  amt;
    logic [63:0] res;
    ovf = |shift_amount[63:6];
    amt = shift_amount[5:0];
    case (mode)
      OP_SRL:  res = ovf ? 64'd0 : (data_in >> amt);
      OP_SLL:  res = ovf ? 64'd0 : (data_in << amt);
      OP_SRA:  res = ovf ? {64{data_in[63]}} : ($signed(data_in) >>> amt);
      OP_RSV:  res = data_in;
      default: res = data_in;
    endcase
    return res;
  endfunction

  logic              adv1_s;
  logic              adv2_s;
  logic [1:0]        grant_s;
  logic              accept_s;
  logic              sel_src_s;
  logic [1:0]        sel_op_s;
  logic [31:0]       sel_operand_s;
  logic [4:0]        sel_shamt_s;
  logic [TAG_W-1:0]  sel_tag_s;

  logic              rr_ptr_q,     rr_ptr_d;
  logic              s1_valid_q,   s1_valid_d;
  logic [1:0]        s1_op_q,      s1_op_d;
  logic [31:0]       s1_operand_q, s1_operand_d;
  logic [4:0]        s1_shamt_q,   s1_shamt_d;
  logic [TAG_W-1:0]  s1_tag_q,     s1_tag_d;
  logic              s1_src_q,     s1_src_d;

  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q,  resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q,   resp_tag_d;
  logic              resp_src_q,   resp_src_d;
  logic              resp_err_q,   resp_err_d;

  logic              sign_s;
  logic [63:0]       shift_in_s;
  logic [63:0]       shift_out_s;
  logic              unused_hi_s;

  assign adv2_s = ~resp_valid_q | resp_ready_i;
  assign adv1_s = ~s1_valid_q | adv2_s;

  // Grant: favoured port first (round-robin) or port 0 first (fixed priority).
  always_comb begin
    grant_s = 2'b00;
    if ((RR_EN != 32'd0) && rr_ptr_q) begin
      if (req_valid_i[1]) begin
        grant_s = 2'b10;
      end else if (req_valid_i[0]) begin
        grant_s = 2'b01;
      end else begin
        grant_s = 2'b00;
      end
    end else begin
      if (req_valid_i[0]) begin
        grant_s = 2'b01;
      end else if (req_valid_i[1]) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b00;
      end
    end
  end

  assign req_ready_o   = grant_s & {2{adv1_s & ~rst_i}};
  assign accept_s      = |(req_valid_i & req_ready_o);
  assign sel_src_s     = grant_s[1];
  assign sel_op_s      = sel_src_s ? req_op_i[3:2]       : req_op_i[1:0];
  assign sel_operand_s = sel_src_s ? req_operand_i[63:32] : req_operand_i[31:0];
  assign sel_shamt_s   = sel_src_s ? req_shamt_i[9:5]    : req_shamt_i[4:0];
  assign sel_tag_s     = sel_src_s ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];

  // Round-robin pointer moves to the port that lost the accepted grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_s && (RR_EN != 32'd0)) begin
      rr_ptr_d = ~sel_src_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Stage 1 next state: load the winner when the stage can advance.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_operand_d = s1_operand_q;
    s1_shamt_d   = s1_shamt_q;
    s1_tag_d     = s1_tag_q;
    s1_src_d     = s1_src_q;
    if (adv1_s) begin
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_op_d      = sel_op_s;
        s1_operand_d = sel_operand_s;
        s1_shamt_d   = sel_shamt_s;
        s1_tag_d     = sel_tag_s;
        s1_src_d     = sel_src_s;
      end else begin
        s1_op_d      = s1_op_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // SRA sign-extends the operand into the upper half; other ops zero-extend.
  assign sign_s      = (s1_op_q == OP_SRA) & s1_operand_q[31];
  assign shift_in_s  = {{32{sign_s}}, s1_operand_q};
  assign shift_out_s = shifter_64bit(shift_in_s, {59'd0, s1_shamt_q}, s1_op_q);
  assign unused_hi_s = ^shift_out_s[63:32];

  // Stage 2 next state: capture the shifter result when the consumer side advances.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    resp_src_d   = resp_src_q;
    resp_err_d   = resp_err_q;
    if (adv2_s) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_data_d = shift_out_s[31:0];
        resp_tag_d  = s1_tag_q;
        resp_src_d  = s1_src_q;
        resp_err_d  = (s1_op_q == OP_RSV);
      end else begin
        resp_data_d = resp_data_q;
      end
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // Pipeline and arbitration state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 2'b00;
      s1_operand_q <= 32'd0;
      s1_shamt_q   <= 5'd0;
      s1_tag_q     <= {TAG_W{1'b0}};
      s1_src_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_tag_q   <= {TAG_W{1'b0}};
      resp_src_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_operand_q <= s1_operand_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_tag_q     <= s1_tag_d;
      s1_src_q     <= s1_src_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_src_q   <= resp_src_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_tag_o   = resp_tag_q;
  assign resp_src_o   = resp_src_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: a round-robin instance is scoreboarded,
// a fixed-priority instance on the same inputs is checked for grant order.
module tb_shift_unit_arbiter;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        src;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic        resp_ready = 1'b1;
  logic [1:0]  op_v   [2];
  logic [31:0] opnd_v [2];
  logic [4:0]  sh_v   [2];
  logic [3:0]  tag_v  [2];

  logic [3:0]  req_op;
  logic [63:0] req_operand;
  logic [9:0]  req_shamt;
  logic [7:0]  req_tag;
  assign req_op      = {op_v[1], op_v[0]};
  assign req_operand = {opnd_v[1], opnd_v[0]};
  assign req_shamt   = {sh_v[1], sh_v[0]};
  assign req_tag     = {tag_v[1], tag_v[0]};

  logic [1:0]  req_ready, fp_req_ready;
  logic        resp_valid, fp_resp_valid;
  logic [31:0] resp_data, fp_resp_data;
  logic [3:0]  resp_tag, fp_resp_tag;
  logic        resp_src, fp_resp_src;
  logic        resp_err, fp_resp_err;

  resp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic [1:0] acc, accf;
  int tag_ctr = 0;

  shift_unit_arbiter #(.TAG_W(TAG_W), .RR_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_operand_i(req_operand), .req_shamt_i(req_shamt), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_tag_o(resp_tag), .resp_src_o(resp_src), .resp_err_o(resp_err));

  shift_unit_arbiter #(.TAG_W(TAG_W), .RR_EN(0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(fp_req_ready),
    .req_op_i(req_op), .req_operand_i(req_operand), .req_shamt_i(req_shamt), .req_tag_i(req_tag),
    .resp_valid_o(fp_resp_valid), .resp_ready_i(resp_ready), .resp_data_o(fp_resp_data),
    .resp_tag_o(fp_resp_tag), .resp_src_o(fp_resp_src), .resp_err_o(fp_resp_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
    case (op)
      2'b00:   return a >> sh;
      2'b01:   return a << sh;
      2'b10:   return $signed(a) >>> sh;
      default: return a;
    endcase
  endfunction

  function automatic resp_t exp_of(input int p);
    resp_t r;
    r.data = ref_shift(op_v[p], opnd_v[p], sh_v[p]);
    r.tag  = tag_v[p];
    r.src  = (p == 1);
    r.err  = (op_v[p] == 2'b11);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] sh, input logic [3:0] tg);
    op_v[p] = op; opnd_v[p] = a; sh_v[p] = sh; tag_v[p] = tg;
    req_valid[p] = 1'b1;
  endtask

  // One clock: sample handshakes at the falling edge, update scoreboard, return 1 after rise.
  task automatic tick(output logic [1:0] a_rr, output logic [1:0] a_fp);
    resp_t e;
    @(negedge clk);
    a_rr = req_valid & req_ready;
    a_fp = req_valid & fp_req_ready;
    if (resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", resp_data, e.data);
        check("sb_tag", resp_tag, e.tag);
        check("sb_src", resp_src, e.src);
        check("sb_err", resp_err, e.err);
      end
    end
    for (int i = 0; i < 2; i++) if (a_rr[i]) sb_q.push_back(exp_of(i));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    logic [1:0] a, b;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick(a, b);
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      op_v[i] = 2'b00; opnd_v[i] = 32'd0; sh_v[i] = 5'd0; tag_v[i] = 4'd0;
    end
    // Reset state, with requests pending to show ready stays low.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_resp_src_err", {resp_src, resp_err}, 0);
    check("rst_fp_resp_valid", fp_resp_valid, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick(acc, accf);

    // Port0 SLL 1 by 31, latency two edges.
    set_req(0, 2'b01, 32'h0000_0001, 5'd31, 4'd3);
    tick(acc, accf);
    check("t1_grant", acc, 2'b01);
    req_valid = 2'b00;
    check("t1_not_yet", resp_valid, 0);
    tick(acc, accf);
    check("t1_valid", resp_valid, 1);
    check("t1_data", resp_data, 32'h8000_0000);
    check("t1_tag_src", {resp_tag, resp_src, resp_err}, {4'd3, 1'b0, 1'b0});
    drain("t1_drain");

    // Port1 SRA then SRL back to back.
    set_req(1, 2'b10, 32'h8000_0000, 5'd4, 4'd5);
    tick(acc, accf);
    check("t2_grant_a", acc, 2'b10);
    set_req(1, 2'b00, 32'h8000_0000, 5'd4, 4'd6);
    tick(acc, accf);
    check("t2_grant_b", acc, 2'b10);
    req_valid = 2'b00;
    check("t2_sra", resp_data, 32'hF800_0000);
    tick(acc, accf);
    check("t2_srl", resp_data, 32'h0800_0000);
    check("t2_src", resp_src, 1);
    drain("t2_drain");

    // Reserved op passes operand through and flags an error.
    set_req(0, 2'b11, 32'hDEAD_BEEF, 5'd7, 4'd9);
    tick(acc, accf);
    req_valid = 2'b00;
    tick(acc, accf);
    check("t3_data", resp_data, 32'hDEAD_BEEF);
    check("t3_err", resp_err, 1);
    drain("t3_drain");

    // Boundaries: shamt 0 and SRA by 31 of a negative value.
    set_req(0, 2'b00, 32'h1234_5678, 5'd0, 4'd10);
    tick(acc, accf);
    set_req(0, 2'b10, 32'h8000_0001, 5'd31, 4'd11);
    tick(acc, accf);
    req_valid = 2'b00;
    check("t6_shamt0", resp_data, 32'h1234_5678);
    tick(acc, accf);
    check("t6_sra31", resp_data, 32'hFFFF_FFFF);
    drain("t6_drain");

    // Both ports valid for 8 cycles; last accept was port0 so port1 is favoured first.
    for (int p = 0; p < 2; p++)
      set_req(p, 2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)), 4'(tag_ctr++));
    for (int k = 0; k < 8; k++) begin
      tick(acc, accf);
      check("rr_grant", acc, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("fp_grant", accf, 2'b01);
      for (int p = 0; p < 2; p++)
        if (acc[p]) set_req(p, 2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)), 4'(tag_ctr++));
    end
    req_valid = 2'b00;
    drain("t4_drain");

    // Backpressure with both stages full.
    resp_ready = 1'b0;
    set_req(0, 2'b01, 32'h0000_00F0, 5'd8, 4'd1);
    tick(acc, accf);
    check("t5_acc_a", acc, 2'b01);
    req_valid = 2'b00;
    set_req(1, 2'b00, 32'hF000_0000, 5'd12, 4'd2);
    tick(acc, accf);
    check("t5_acc_b", acc, 2'b10);
    req_valid = 2'b00;
    set_req(0, 2'b10, 32'h9000_0000, 5'd1, 4'd4);
    for (int k = 0; k < 5; k++) begin
      tick(acc, accf);
      check("t5_stall_ready", req_ready, 2'b00);
      check("t5_stall_valid", resp_valid, 1);
      check("t5_stall_data", resp_data, 32'h0000_F000);
      check("t5_stall_tag", resp_tag, 4'd1);
    end
    resp_ready = 1'b1;
    tick(acc, accf);
    check("t5_acc_c_on_drain", acc, 2'b01);
    req_valid = 2'b00;
    drain("t5_drain");

    // Reset mid-operation flushes both stages and the round-robin pointer.
    resp_ready = 1'b0;
    set_req(1, 2'b01, 32'h0000_0003, 5'd2, 4'd7);
    tick(acc, accf);
    req_valid = 2'b00;
    set_req(0, 2'b00, 32'h0000_0F00, 5'd4, 4'd8);
    tick(acc, accf);
    check("t7_fill_acc", acc, 2'b01);
    check("t7_full", resp_valid, 1);
    rst = 1'b1;
    #1;
    check("t7_rst_valid", resp_valid, 0);
    check("t7_rst_data", resp_data, 0);
    check("t7_rst_ready", req_ready, 2'b00);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    set_req(1, 2'b10, 32'h8000_0010, 5'd3, 4'd12);
    tick(acc, accf);
    check("t7_first_grant", acc, 2'b01);
    tick(acc, accf);
    check("t7_second_grant", acc, 2'b10);
    req_valid = 2'b00;
    drain("t7_drain");
    tick(acc, accf);
    check("final_idle", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
